bus_bridge_mc: RTL and testbench
================================

Name: bus_bridge_mc

Overview:
Parametrised successor to the fixed single-cycle CPU↔peripheral bridge. It decodes CPU bus accesses onto N_CH memory-mapped channels, such as DRAM, 7-seg digits, LEDs, switches and buttons, using per-channel base/mask windows. Every access uses a req/ready handshake, so slow slaves may insert wait states. A per-access timeout and an unmapped-address error path return a defined response instead of hanging the core. It sits between myCPU's bus port and the peripheral interface modules in the SoC top.

Parameters:
N_CH, 5, number of slave channels (1..8)
AW, 32, CPU address width
DW, 32, data width
OFF_W, 12, offset bits forwarded to slaves (ch_addr = addr[OFF_W-1:0])
CH_BASE, {32'hFFFF_F078, 32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000}, packed N_CH*AW; channel i base at slice i (channel 0 = DRAM)
CH_MASK, {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_C000}, packed N_CH*AW; channel i hits when (addr & mask_i) == base_i
TIMEOUT, 15, max ACCESS cycles waiting for ch_ready (≥1)
ERR_RDATA, 32'h0000_0000, rdata returned with err

Ports:
clk  in  1  bridge/CPU clock
rst_n  in  1  asynchronous reset, active low
cpu_req  in  1  access request; held high until cpu_ready
cpu_wen  in  1  1 = write, 0 = read
cpu_addr  in  AW  byte address
cpu_wdata  in  DW  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid when cpu_ready
cpu_err  out  1  error flag, valid when cpu_ready
ch_sel  out  N_CH  one-hot channel strobe
ch_wen  out  1  write enable, qualified by ch_sel
ch_addr  out  OFF_W  offset
ch_wdata  out  DW  write data
ch_rdata  in  N_CH*DW  packed per-channel read data
ch_ready  in  N_CH  per-channel done (tie 1 for single-cycle slaves)
err_count  out  8  saturating count of errored accesses

Behaviour:
- Reset (async assert, sync release): state=IDLE. cpu_ready=0, cpu_err=0, cpu_rdata=0, ch_sel=0, ch_wen=0, ch_addr=0, ch_wdata=0, err_count=0, timeout counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: cpu_req is sampled only here. On cpu_req=1, latch wen/addr/wdata and decode.
  - Decode priority: lowest matching index wins.
  - Hit: go to ACCESS with sel_q = one-hot(i) and tcnt=0.
  - No hit: go to RESP with err=1 and rdata=ERR_RDATA. No ch_sel is asserted.
- ACCESS: ch_sel=sel_q, ch_wen=wen_q, ch_addr=addr_q[OFF_W-1:0], ch_wdata=wdata_q. All are registered and stable for the whole state.
  - If ch_ready[sel]: capture ch_rdata slice (ERR_RDATA on write) and go to RESP with err=0.
  - Else if tcnt==TIMEOUT-1: go to RESP with err=1 and rdata=ERR_RDATA.
  - Else: tcnt+1.
  - A channel with ch_ready stuck high completes in exactly one ACCESS cycle. A write commits at most once per ACCESS cycle, and the slave must treat ch_sel&ch_wen as a per-cycle strobe.
- RESP: cpu_ready=1 for exactly one cycle with cpu_rdata/cpu_err; ch_sel=0; next state IDLE.
  - cpu_rdata holds its value after RESP until the next RESP. cpu_err is cleared in IDLE.
- Latency: a single-cycle slave needs 3 cycles from request accept to cpu_ready (IDLE, ACCESS, RESP). An unmapped address needs 2 cycles. A timeout needs TIMEOUT+2 cycles.
- Handshake: the CPU drops or replaces cpu_req in the cycle after cpu_ready. A cpu_req seen in IDLE immediately after RESP is a new access (back-to-back allowed). Changes to cpu_req/addr outside IDLE are ignored.
- err_count increments on every RESP with err=1 and saturates at 8'hFF.
- If rst_n is asserted mid-ACCESS, all outputs return to reset values at once. The pending access is dropped with no cpu_ready, and a write in flight may or may not have committed.
- Width rules: tcnt is $clog2(TIMEOUT+1) bits. The decode compare is a full AW-bit compare.

Decomposition:
- Shared package bus_bridge_pkg: state encoding, ERR_RDATA default, default CH_BASE/CH_MASK constants for the standard SoC map (DRAM 0x0000_0000, DIG 0xFFFF_F000, LED 0xFFFF_F060, SW 0xFFFF_F070, BTN 0xFFFF_F078).
- One sub-module, addr_decoder: combinational; addr + packed base/mask in, one-hot hit + any_hit out, priority to lowest index.

Test Plan:
1. Reset release, read 0x0000_0010 with ch_ready[0]=1 and ch_rdata[0]=32'h1234_5678 -> ch_sel=5'b00001 for 1 cycle, cpu_ready 3 cycles after accept, cpu_rdata=32'h1234_5678, cpu_err=0.
2. Write 0xFFFF_F060 with wdata=32'h00AB_CDEF -> ch_sel=5'b00100, ch_wen=1, ch_addr=12'h060 for exactly one cycle, then cpu_ready with err=0.
3. Read 0x8000_0000 (unmapped) -> no ch_sel, cpu_ready 2 cycles after accept, cpu_err=1, rdata=0, err_count=1.
4. Read 0xFFFF_F070 with ch_ready[3] held low -> ch_sel held 15 cycles, then cpu_ready with err=1. Repeat the test with ch_ready[3] raised in the 4th ACCESS cycle -> err=0, ch_rdata[3] value returned.
5. Back-to-back: read DRAM, then write LEDs with req re-asserted in the cycle after cpu_ready -> second accept in that cycle, no lost or duplicated strobe. Also drive 300 unmapped accesses -> err_count saturates at 8'hFF.
6. Assert rst_n low in the 2nd ACCESS cycle of a stalled access -> ch_sel=0 immediately and no cpu_ready pulse. After release, a fresh read completes normally.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_bridge_pkg
// Purpose : Shared types and constants for the multi-channel CPU bus bridge.
//           Holds the FSM state encoding, the default error read data and the
//           standard SoC address map (DRAM, 7-seg digits, LEDs, switches,
//           buttons) as packed base/mask vectors, channel 0 in the low slice.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_ERR_RDATA = 32'h0000_0000;

  // Channel order, high slice first: BTN, SW, LED, DIG, DRAM.
  localparam logic [5*32-1:0] DEF_CH_BASE = {
    32'hFFFF_F078, 32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000
  };

  localparam logic [5*32-1:0] DEF_CH_MASK = {
    32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_C000
  };

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : addr_decoder
// Purpose : Combinational address window decoder. Channel i matches when
//           (addr & mask_i) == base_i over the full address width; when
//           several windows overlap the lowest index wins.
// Ports   : addr    in  AW        address to decode
//           base    in  N_CH*AW   packed per-channel base addresses
//           mask    in  N_CH*AW   packed per-channel masks
//           hit     out N_CH      one-hot winning channel (0 when no match)
//           any_hit out 1         at least one window matched
// Rev     : 1.0 - initial release
// ============================================================================
module addr_decoder
  import bus_bridge_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int AW   = 32
) (
  input  logic [AW-1:0]      addr,
  input  logic [N_CH*AW-1:0] base,
  input  logic [N_CH*AW-1:0] mask,
  output logic [N_CH-1:0]    hit,
  output logic               any_hit
);

  logic [N_CH-1:0] match;

  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    assign match[i] = ((addr & mask[i*AW +: AW]) == base[i*AW +: AW]);
  end

  // Isolate the lowest set bit: two's complement trick gives priority to
  // the lowest channel index.
  assign hit     = match & (~match + {{(N_CH-1){1'b0}}, 1'b1});
  assign any_hit = |match;

endmodule
`default_nettype wire

// File: rtl/bus_bridge_mc.sv
`default_nettype none
// ============================================================================
// Module  : bus_bridge_mc
// Purpose : CPU to N_CH-channel peripheral bridge with req/ready handshake,
//           per-access timeout and unmapped-address error response.
//           FSM IDLE -> ACCESS -> RESP (IDLE -> RESP on unmapped address).
// Ports   : clk, rst_n                 clock, async active-low reset
//           cpu_req/wen/addr/wdata     CPU request (held until cpu_ready)
//           cpu_ready/rdata/err        one-cycle response
//           ch_sel/wen/addr/wdata      registered channel strobes
//           ch_rdata, ch_ready         packed per-channel slave returns
//           err_count                  saturating count of errored accesses
// Rev     : 1.0 - initial release
// ============================================================================
module bus_bridge_mc
  import bus_bridge_pkg::*;
#(
  parameter int                  N_CH      = 5,
  parameter int                  AW        = 32,
  parameter int                  DW        = 32,
  parameter int                  OFF_W     = 12,
  parameter logic [N_CH*AW-1:0]  CH_BASE   = DEF_CH_BASE,
  parameter logic [N_CH*AW-1:0]  CH_MASK   = DEF_CH_MASK,
  parameter int                  TIMEOUT   = 15,
  parameter logic [DW-1:0]       ERR_RDATA = DW'(DEF_ERR_RDATA)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_wen,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic                 cpu_ready,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_err,
  output logic [N_CH-1:0]      ch_sel,
  output logic                 ch_wen,
  output logic [OFF_W-1:0]     ch_addr,
  output logic [DW-1:0]        ch_wdata,
  input  logic [N_CH*DW-1:0]   ch_rdata,
  input  logic [N_CH-1:0]      ch_ready,
  output logic [7:0]           err_count
);

  localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   sel_q, sel_d;
  logic              wen_q, wen_d;
  logic [OFF_W-1:0]  addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [7:0]        errcnt_q, errcnt_d;

  logic [N_CH-1:0]   dec_hit;
  logic              dec_any;
  logic [DW-1:0]     sel_rdata;
  logic              sel_ready;

  addr_decoder #(
    .N_CH (N_CH),
    .AW   (AW)
  ) u_dec (
    .addr    (cpu_addr),
    .base    (CH_BASE),
    .mask    (CH_MASK),
    .hit     (dec_hit),
    .any_hit (dec_any)
  );

  // One-hot mux of the selected channel's read data and ready.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | ch_rdata[i*DW +: DW];
      end
    end
  end

  assign sel_ready = |(ch_ready & sel_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tcnt_d   = tcnt_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (cpu_req) begin
          if (dec_any) begin
            // Channel outputs are loaded here so they are registered and
            // stable for every ACCESS cycle.
            sel_d   = dec_hit;
            wen_d   = cpu_wen;
            addr_d  = cpu_addr[OFF_W-1:0];
            wdata_d = cpu_wdata;
            tcnt_d  = '0;
            state_d = ST_ACCESS;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = wen_q ? ERR_RDATA : sel_rdata;
          sel_d   = '0;
          wen_d   = 1'b0;
          state_d = ST_RESP;
        end else if (tcnt_q == TCNT_LAST) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          sel_d   = '0;
          wen_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_RESP: begin
        // err is visible only alongside cpu_ready; rdata keeps its value.
        err_d   = 1'b0;
        state_d = ST_IDLE;
        if (err_q) begin
          errcnt_d = sat_inc8(errcnt_q);
        end
      end

      default: begin
        sel_d   = '0;
        wen_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tcnt_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tcnt_q   <= tcnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign cpu_ready = ready_q;
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign ch_sel    = sel_q;
  assign ch_wen    = wen_q;
  assign ch_addr   = addr_q;
  assign ch_wdata  = wdata_q;
  assign err_count = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_bridge_mc
// Purpose : Self-checking bench for bus_bridge_mc with the default 5-channel
//           SoC map. Slave models raise ch_ready after a programmable number
//           of selected cycles (-1 = never) and count write strobes.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_bus_bridge_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_wen;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [4:0]   ch_sel;
  logic         ch_wen;
  logic [11:0]  ch_addr;
  logic [31:0]  ch_wdata;
  logic [159:0] ch_rdata;
  logic [4:0]   ch_ready;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;

  int stall [5] = '{default: 0};
  int cnt   [5] = '{default: 0};
  int wr_cnt    = 0;
  int exp_errcnt = 0;

  logic [32:0] sb_q [$];

  bus_bridge_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .ch_sel    (ch_sel),
    .ch_wen    (ch_wen),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_rdata  (ch_rdata),
    .ch_ready  (ch_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_ready = '0;
    for (int i = 0; i < 5; i++) begin
      ch_ready[i] = (stall[i] >= 0) && (cnt[i] >= stall[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      cnt[i] <= ch_sel[i] ? cnt[i] + 1 : 0;
    end
    if ((|ch_sel) && ch_wen) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one access starting now (just after a rising edge) and checks the
  // strobes, latency and response; returns one cycle after cpu_ready.
  task automatic access(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] exp_sel,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat);
    int          n;
    int          sel_cycles;
    int          w0;
    int          exp_sel_cycles;
    logic        done;
    logic [32:0] e;
    cpu_req   = 1'b1;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    sb_q.push_back({exp_err, exp_rdata});
    exp_sel_cycles = (exp_sel == 5'b0) ? 0 : exp_lat - 2;
    w0 = wr_cnt;
    n = 0;
    sel_cycles = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ready) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_selcyc"}, sel_cycles, exp_sel_cycles);
        check({tag, "_rdata"}, cpu_rdata, e[31:0]);
        check({tag, "_err"}, cpu_err, e[32]);
        check({tag, "_sel_resp"}, ch_sel, 5'b0);
      end else if (ch_sel != 5'b0) begin
        sel_cycles++;
        check({tag, "_sel"}, ch_sel, exp_sel);
        check({tag, "_chwen"}, ch_wen, wen);
        check({tag, "_chaddr"}, ch_addr, addr[11:0]);
        if (wen) check({tag, "_chwdata"}, ch_wdata, wdata);
      end
    end
    check({tag, "_ready_seen"}, done, 1'b1);
    if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    if (exp_err && exp_errcnt < 255) exp_errcnt++;
    check({tag, "_errcnt"}, err_count, exp_errcnt);
    check({tag, "_rdata_hold"}, cpu_rdata, exp_rdata);
    check({tag, "_err_idle"}, cpu_err, 1'b0);
    check({tag, "_writes"}, wr_cnt - w0, (wen && exp_sel != 5'b0) ? exp_sel_cycles : 0);
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ch_rdata  = '0;
    ch_rdata[0*32 +: 32] = 32'h1234_5678;
    ch_rdata[2*32 +: 32] = 32'h0000_00AA;
    ch_rdata[3*32 +: 32] = 32'hCAFE_0003;
    ch_rdata[4*32 +: 32] = 32'h0000_00B7;

    repeat (3) @(negedge clk);
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_err", cpu_err, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_sel", ch_sel, 5'b0);
    check("rst_wen", ch_wen, 1'b0);
    check("rst_addr", ch_addr, 12'h0);
    check("rst_wdata", ch_wdata, 32'h0);
    check("rst_errcnt", err_count, 8'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DRAM read, single-cycle slave
    access("t1_dram_rd", 1'b0, 32'h0000_0010, 32'h0, 5'b00001, 32'h1234_5678, 1'b0, 3);
    // LED write
    access("t2_led_wr", 1'b1, 32'hFFFF_F060, 32'h00AB_CDEF, 5'b00100, 32'h0, 1'b0, 3);
    // Unmapped read
    access("t3_unmapped", 1'b0, 32'h8000_0000, 32'h0, 5'b00000, 32'h0, 1'b1, 2);
    // Window edges: BTN inside, just past BTN, just past DRAM
    access("dec_btn", 1'b0, 32'hFFFF_F07B, 32'h0, 5'b10000, 32'h0000_00B7, 1'b0, 3);
    access("dec_btn_past", 1'b0, 32'hFFFF_F07C, 32'h0, 5'b00000, 32'h0, 1'b1, 2);
    access("dec_dram_top", 1'b0, 32'h0000_3FFC, 32'h0, 5'b00001, 32'h1234_5678, 1'b0, 3);
    access("dec_dram_past", 1'b0, 32'h0000_4000, 32'h0, 5'b00000, 32'h0, 1'b1, 2);

    // Switch channel timeout, then ready raised in 4th ACCESS cycle
    stall[3] = -1;
    access("t4_timeout", 1'b0, 32'hFFFF_F070, 32'h0, 5'b01000, 32'h0, 1'b1, 17);
    stall[3] = 3;
    access("t4_wait", 1'b0, 32'hFFFF_F070, 32'h0, 5'b01000, 32'hCAFE_0003, 1'b0, 6);
    stall[3] = 0;

    // Back-to-back: request re-asserted the cycle after cpu_ready
    access("t5_b2b_rd", 1'b0, 32'h0000_0020, 32'h0, 5'b00001, 32'h1234_5678, 1'b0, 3);
    access("t5_b2b_wr", 1'b1, 32'hFFFF_F064, 32'h0000_0055, 5'b00100, 32'h0, 1'b0, 3);

    for (int k = 0; k < 300; k++) begin
      access("t5_sat", 1'b0, 32'h8000_0000 + 32'(k * 4), 32'h0, 5'b00000, 32'h0, 1'b1, 2);
    end
    check("t5_sat_final", err_count, 8'hFF);

    // Reset during the second ACCESS cycle of a stalled access
    stall[3] = -1;
    @(posedge clk);
    #1;
    cpu_req  = 1'b1;
    cpu_wen  = 1'b0;
    cpu_addr = 32'hFFFF_F070;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_sel", ch_sel, 5'b01000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sel_now", ch_sel, 5'b0);
    check("t6_ready_now", cpu_ready, 1'b0);
    check("t6_errcnt_now", err_count, 8'h0);
    check("t6_addr_now", ch_addr, 12'h0);
    cpu_req = 1'b0;
    exp_errcnt = 0;
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
    end
    check("t6_no_ready", seen, 1'b0);
    stall[3] = 0;
    @(posedge clk);
    #1;
    access("t6_fresh", 1'b0, 32'h0000_0100, 32'h0, 5'b00001, 32'h1234_5678, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
